// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its helpers.
//   - RISC-V opcodes for loads and stores
//   - funct3 size codes (signed and unsigned variants)
//   - FSM state encoding
//   - small decode helpers (access size, funct3 legality)
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StResp
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; encodings above 2 are rejected elsewhere.
  function automatic int unsigned size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed lane of a memory word and
// sign- or zero-extends it according to funct3.
// Ports:
//   rdata   in   XLEN              raw memory word
//   offset  in   log2(XLEN/8)      byte offset of the access inside the word
//   funct3  in   3                 load size/sign code
//   data    out  XLEN              extended load result
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]             rdata,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [2:0]                  funct3,
  output logic [XLEN-1:0]             data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    // Move the addressed byte down to lane 0.
    lane = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_H:    data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit. Accepts one decoded load/store per handshake,
// computes the effective address, performs one req/ack memory access and
// returns aligned/extended load data with a register-file write strobe.
// Misaligned, illegal-funct3 and timed-out accesses return an error response.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in idle)
//   inst, rs1_data, rs2_data         instruction, base address, store data
//   mem_req/we/addr/be/wdata         memory request, held until mem_ack
//   mem_ack, mem_rdata               memory completion and read word
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_rd, rsp_werf, rsp_err  response payload
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned MISALIGN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_werf,
  output logic              rsp_err
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFFW   = $clog2(NBYTES);
  localparam int unsigned CNTW   = $clog2(TIMEOUT + 1);

  // Request decode (combinational, used only on the accept cycle)
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [11:0]       imm;
  logic              is_load, is_store, legal, misaligned;
  logic [XLEN-1:0]   addr, rep, wdata;
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   shamt;
  logic [NBYTES-1:0] size_mask, be;
  int unsigned       sz;

  // The rs1 register index is resolved upstream; only the data is used here.
  logic unused_inst;
  assign unused_inst = ^inst[19:15];

  always_comb begin
    opcode   = inst[6:0];
    rd       = inst[11:7];
    funct3   = inst[14:12];
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    imm      = is_store ? {inst[31:25], inst[11:7]} : inst[31:20];
    addr     = rs1_data + {{(XLEN-12){imm[11]}}, imm};
    off      = addr[OFFW-1:0];
    sz       = size_bytes(funct3[1:0]);
    legal    = funct3_legal(is_load, funct3);
    if (MISALIGN == 0) begin
      misaligned = (32'(off) & (sz - 32'd1)) != 32'd0;
    end else begin
      // Unaligned accesses are fine as long as they stay inside one word.
      misaligned = (32'(off) + sz) > NBYTES;
    end
    size_mask = NBYTES'((32'd1 << sz) - 32'd1);
    be        = size_mask << off;
    case (funct3[1:0])
      2'b00:   rep = {NBYTES{rs2_data[7:0]}};
      2'b01:   rep = {(NBYTES/2){rs2_data[15:0]}};
      default: rep = {(NBYTES/4){rs2_data[31:0]}};
    endcase
    // Rotating the replicated pattern by the byte offset keeps the data in the
    // enabled lanes even when an unaligned half sits across a half boundary;
    // for aligned accesses the rotation is a no-op.
    shamt = {off, 3'b000};
    wdata = (rep << shamt) | (rep >> (XLEN - 32'(shamt)));
  end

  // Transaction state
  lsu_state_e      state_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      funct3_q;
  logic [OFFW-1:0] off_q;
  logic            is_load_q;
  logic [XLEN-1:0] load_data;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      is_load_q <= 1'b0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_werf  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_rd    <= rd;
            funct3_q  <= funct3;
            off_q     <= off;
            is_load_q <= is_load;
            cnt_q     <= '0;
            if ((is_load || is_store) && legal && !misaligned) begin
              state_q   <= StMem;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_be    <= be;
              mem_wdata <= is_store ? wdata : '0;
            end else begin
              // Non-memory opcodes pass straight through without an error.
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= is_load || is_store;
              rsp_werf  <= 1'b0;
              rsp_data  <= '0;
            end
          end
        end
        StMem: begin
          if (mem_ack || (cnt_q == CNTW'(TIMEOUT - 1))) begin
            state_q   <= StResp;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= !mem_ack;
            rsp_werf  <= mem_ack && is_load_q;
            rsp_data  <= (mem_ack && is_load_q) ? load_data : '0;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_werf  <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
